// File: rtl/stopwatch_pkg.sv
// Shared types and seven-segment constants for the stopwatch display path.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package stopwatch_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_E     = 7'b0000110;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Non-decimal codes 10..15 display "E".
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_E;
    case (bcd_i)
      4'd0: seg_o = SEG_DIGIT[0];
      4'd1: seg_o = SEG_DIGIT[1];
      4'd2: seg_o = SEG_DIGIT[2];
      4'd3: seg_o = SEG_DIGIT[3];
      4'd4: seg_o = SEG_DIGIT[4];
      4'd5: seg_o = SEG_DIGIT[5];
      4'd6: seg_o = SEG_DIGIT[6];
      4'd7: seg_o = SEG_DIGIT[7];
      4'd8: seg_o = SEG_DIGIT[8];
      4'd9: seg_o = SEG_DIGIT[9];
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed common-anode display scanner with per-frame snapshot of the MM:SS value.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero in the leftmost digit.
module bcd_display_scanner
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DP_DIGIT    = 2
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic [16:1] Q,
  input  logic        HOLD,
  output logic [7:1]  SEG,
  output logic        DP,
  output logic [4:1]  AN,
  output logic        FRAME
);

  localparam logic [19:0] PRESC_LAST = 20'(REFRESH_DIV - 1);
  localparam digit_idx_t  DP_IDX     = digit_idx_t'(DP_DIGIT);

  logic [19:0] presc_q;
  digit_idx_t  idx_q, idx_d;
  logic [15:0] snap_q, snap_d;
  seg_t        seg_q, seg_d, dec_seg;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;
  logic        frame_q;
  logic        tick, wrap, load;
  logic [3:0]  nibble;

  assign tick = (presc_q == PRESC_LAST);
  assign wrap = tick && (idx_q == 2'd3);
  assign load = wrap && !HOLD;

  assign idx_d  = idx_q + 2'd1;
  assign snap_d = load ? Q : snap_q;
  // Decode from the snapshot as it will be after this edge, so digit 0 of a new frame is fresh.
  assign nibble = snap_d[{idx_d, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .bcd_i (nibble),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
    // Anode still enabled so every slot has the same on-time.
    if (idx_d == 2'd3 && nibble == 4'd0)
      seg_d = SEG_BLANK;
`else
`endif
    an_d = ~(4'b0001 << idx_d);
    dp_d = (idx_d != DP_IDX);
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q <= '0;
      idx_q   <= 2'd3;
      snap_q  <= '0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 20'd1;
      frame_q <= load;
      snap_q  <= snap_d;
      if (tick) begin
        idx_q <= idx_d;
        seg_q <= seg_d;
        dp_q  <= dp_d;
        an_q  <= an_d;
      end
    end
  end

  assign SEG   = seg_q;
  assign DP    = dp_q;
  assign AN    = an_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench: a REFRESH_DIV=4 scanner driven from a vector table, plus a REFRESH_DIV=1 scanner
// checked in a hand-written sequence alongside the mid-slot reset case.
module tb_bcd_display_scanner;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SZ = SB;
`else
  localparam logic [6:0] SZ = S0;
`endif

  typedef struct {
    logic [15:0] q;
    logic        hold;
    int          adv;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:1] q;
  logic        hold;
  logic [7:1]  seg;
  logic        dp;
  logic [4:1]  an;
  logic        frame;

  logic [16:1] q_fast = 16'h0945;
  logic [7:1]  seg_f;
  logic        dp_f;
  logic [4:1]  an_f;
  logic        frame_f;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  bcd_display_scanner #(.REFRESH_DIV(4), .DP_DIGIT(2)) dut (
    .clk(clk), .RESET_N(rst_n), .Q(q), .HOLD(hold),
    .SEG(seg), .DP(dp), .AN(an), .FRAME(frame)
  );

  bcd_display_scanner #(.REFRESH_DIV(1), .DP_DIGIT(2)) dut_fast (
    .clk(clk), .RESET_N(rst_n), .Q(q_fast), .HOLD(1'b0),
    .SEG(seg_f), .DP(dp_f), .AN(an_f), .FRAME(frame_f)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_slow(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dp, input logic e_fr);
    chk({tag, ".AN"},    16'(an),    16'(e_an));
    chk({tag, ".SEG"},   16'(seg),   16'(e_seg));
    chk({tag, ".DP"},    16'(dp),    16'(e_dp));
    chk({tag, ".FRAME"}, 16'(frame), 16'(e_fr));
    $display("%s: AN=%b SEG=%b DP=%b FRAME=%b", tag, an, seg, dp, frame);
  endtask

  task automatic chk_fast(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dp, input logic e_fr);
    chk({tag, ".AN"},    16'(an_f),    16'(e_an));
    chk({tag, ".SEG"},   16'(seg_f),   16'(e_seg));
    chk({tag, ".DP"},    16'(dp_f),    16'(e_dp));
    chk({tag, ".FRAME"}, 16'(frame_f), 16'(e_fr));
    $display("%s: AN=%b SEG=%b DP=%b FRAME=%b", tag, an_f, seg_f, dp_f, frame_f);
  endtask

  initial begin
    // Each row: drive q/hold, advance adv clocks, then compare at the falling edge.
    vecs.push_back('{16'h1020, 1'b0, 4, 4'b1110, S0, 1'b1, 1'b1});
    vecs.push_back('{16'h1020, 1'b0, 1, 4'b1110, S0, 1'b1, 1'b0});
    vecs.push_back('{16'h1020, 1'b0, 3, 4'b1101, S2, 1'b1, 1'b0});
    vecs.push_back('{16'h1020, 1'b0, 4, 4'b1011, S0, 1'b0, 1'b0});
    vecs.push_back('{16'h1020, 1'b0, 4, 4'b0111, S1, 1'b1, 1'b0});
    vecs.push_back('{16'h1020, 1'b0, 4, 4'b1110, S0, 1'b1, 1'b1});
    vecs.push_back('{16'h1020, 1'b0, 4, 4'b1101, S2, 1'b1, 1'b0});
    vecs.push_back('{16'h4030, 1'b0, 4, 4'b1011, S0, 1'b0, 1'b0});
    vecs.push_back('{16'h4030, 1'b0, 4, 4'b0111, S1, 1'b1, 1'b0});
    vecs.push_back('{16'h4030, 1'b0, 4, 4'b1110, S0, 1'b1, 1'b1});
    vecs.push_back('{16'h4030, 1'b0, 4, 4'b1101, S3, 1'b1, 1'b0});
    vecs.push_back('{16'h4030, 1'b0, 4, 4'b1011, S0, 1'b0, 1'b0});
    vecs.push_back('{16'h4030, 1'b0, 4, 4'b0111, S4, 1'b1, 1'b0});
    vecs.push_back('{16'h0159, 1'b0, 4, 4'b1110, S9, 1'b1, 1'b1});
    vecs.push_back('{16'h0159, 1'b0, 4, 4'b1101, S5, 1'b1, 1'b0});
    vecs.push_back('{16'h0159, 1'b0, 4, 4'b1011, S1, 1'b0, 1'b0});
    vecs.push_back('{16'h0159, 1'b0, 4, 4'b0111, SZ, 1'b1, 1'b0});
    vecs.push_back('{16'h0200, 1'b1, 4, 4'b1110, S9, 1'b1, 1'b0});
    vecs.push_back('{16'h0200, 1'b0, 4, 4'b1101, S5, 1'b1, 1'b0});
    vecs.push_back('{16'h0200, 1'b0, 4, 4'b1011, S1, 1'b0, 1'b0});
    vecs.push_back('{16'h0200, 1'b0, 4, 4'b0111, SZ, 1'b1, 1'b0});
    vecs.push_back('{16'h0200, 1'b0, 4, 4'b1110, S0, 1'b1, 1'b1});
    vecs.push_back('{16'h0200, 1'b0, 4, 4'b1101, S0, 1'b1, 1'b0});
    vecs.push_back('{16'h0200, 1'b0, 4, 4'b1011, S2, 1'b0, 1'b0});
    vecs.push_back('{16'h0200, 1'b0, 4, 4'b0111, SZ, 1'b1, 1'b0});
    vecs.push_back('{16'h00C0, 1'b0, 4, 4'b1110, S0, 1'b1, 1'b1});
    vecs.push_back('{16'h00C0, 1'b0, 4, 4'b1101, SE, 1'b1, 1'b0});
    vecs.push_back('{16'h00C0, 1'b0, 4, 4'b1011, S0, 1'b0, 1'b0});
    vecs.push_back('{16'h00C0, 1'b0, 4, 4'b0111, SZ, 1'b1, 1'b0});

    rst_n = 1'b0;
    q     = 16'h1020;
    hold  = 1'b0;
    repeat (2) @(negedge clk);
    chk_slow("reset", 4'b1111, SB, 1'b1, 1'b0);
    chk_fast("reset_fast", 4'b1111, SB, 1'b1, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      q    = vecs[i].q;
      hold = vecs[i].hold;
      repeat (vecs[i].adv) @(negedge clk);
      chk_slow($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dp, vecs[i].frame);
    end

    // Mid-slot asynchronous reset: blank immediately, then restart from the current Q.
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_slow("midrst", 4'b1111, SB, 1'b1, 1'b0);
    chk_fast("midrst_fast", 4'b1111, SB, 1'b1, 1'b0);
    q = 16'h0007;
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      case (k)
        1: chk_fast("fast1", 4'b1110, S5, 1'b1, 1'b1);
        2: chk_fast("fast2", 4'b1101, S4, 1'b1, 1'b0);
        3: chk_fast("fast3", 4'b1011, S9, 1'b0, 1'b0);
        4: chk_fast("fast4", 4'b0111, SZ, 1'b1, 1'b0);
        default: chk_fast("fast5", 4'b1110, S5, 1'b1, 1'b1);
      endcase
      if (k == 3) chk_slow("post_rst_blank", 4'b1111, SB, 1'b1, 1'b0);
      if (k == 4) chk_slow("post_rst_d0", 4'b1110, S7, 1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
